if_inst_queue: RTL and testbench
================================

# if_inst_queue

Instruction fetch queue between the fetch stage (PC register, instruction ROM, PC/valid alignment buffer) and the decoder. Each valid cycle it captures one aligned {pc, inst} pair, buffers up to DEPTH pairs in a first-word-fall-through FIFO, and presents the oldest pair to decode under a valid/ready handshake. It absorbs decoder stalls, requests a fetch stall early enough to cover in-flight fetches, and discards all contents on flush or taken branch.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 4
- ADDR_W, 32, PC width (matches InstAddrBus)
- INST_W, 32, instruction width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- pc_i  in  ADDR_W  fetched PC, aligned with inst_i
- pc_valid_i  in  1  pc_i/inst_i carry a real fetch this cycle
- inst_i  in  INST_W  instruction word for pc_i
- flush_i  in  1  pipeline flush (exception/ertn)
- branch_flag_i  in  1  taken branch/redirect from execute
- id_ready_i  in  1  decoder accepts head entry this cycle
- id_valid_o  out  1  head entry valid
- id_pc_o  out  ADDR_W  head PC
- id_inst_o  out  INST_W  head instruction
- stall_req_o  out  1  fetch-stall request to PC register and alignment buffer
- count_o  out  $clog2(DEPTH)+1  current occupancy
- overflow_o  out  1  sticky: push attempted while full with no pop

## Operation
- Storage: DEPTH entries of {pc, inst}; read pointer rd_ptr, write pointer wr_ptr, both $clog2(DEPTH) bits, wrap naturally modulo DEPTH; count tracks occupancy 0..DEPTH.
- push = pc_valid_i && (count < DEPTH || pop) && !kill, where kill = flush_i || branch_flag_i.
- pop = id_valid_o && id_ready_i && !kill.
- Push writes {pc_i, inst_i} at wr_ptr, then increments wr_ptr. Pop increments rd_ptr. count: +1 push only, −1 pop only, unchanged for both or neither.
- Full with simultaneous pop and push: both happen, count stays DEPTH.
- pc_valid_i while count == DEPTH and no pop: entry dropped, overflow_o set; it stays set until reset. This is an upstream protocol violation.
- kill: rd_ptr, wr_ptr and count go to 0; the same-cycle input is discarded; overflow_o is unaffected. branch_flag_i and flush_i are equivalent here.
- Priority: rst > kill > push/pop.
- Outputs (FWFT): id_valid_o = (count != 0). id_pc_o/id_inst_o = entry[rd_ptr] when valid, otherwise ZeroWord.
- stall_req_o = (count ≥ DEPTH−2), registered-state only. This leaves two slots of skid for fetches already in flight through PC register → alignment buffer.
- No internal FSM beyond the pointer/count state. The empty/partial/full condition is fully determined by count.

## Timing
- Reset (rst low, asynchronous): ptrs 0, count_o 0, id_valid_o 0, id_pc_o 0, id_inst_o 0, stall_req_o 0, overflow_o 0. Storage contents are don't-care.
- Push-to-visible latency: 1 cycle. There is no bypass, so a push into an empty queue shows id_valid_o high the following cycle.
- Pop is effective at the clock edge where id_valid_o && id_ready_i. The next entry appears the following cycle.
- kill asserted at cycle N: id_valid_o low from N+1, and stall_req_o low from N+1.
- stall_req_o and count_o change only on clk edges or asynchronous reset; there is no combinational path from any input.
- Reset deasserted mid-stream: the first push can occur on the first rising edge after release.

## Structure
- Shared defines: ZeroWord, InstAddrBus, InstValid/InstInvalid. Add IfQueueDepth (default 4) to the shared defines file.
- One natural sub-module: fifo_ptr_ctrl (push/pop/kill → rd_ptr, wr_ptr, count, full, empty), parameterised by DEPTH. It is reusable for later queues. Entry storage and output muxing stay in if_inst_queue.

## Test plan
- Reset then 3 pushes (pc 0x1c000000/04/08, id_ready_i=0): count_o=3, stall_req_o=1 after the 2nd push, id_pc_o=0x1c000000, id_valid_o=1.
- Fill to 4 with ready low, then one more pc_valid_i: overflow_o=1, count_o=4, and the head still reads 0x1c000000.
- Full queue with push and pop in the same cycle: count_o stays 4, and the head advances to the next PC. Drain 4 pops to check in-order wrap-around across ptr 3→0.
- Empty queue, push at N with id_ready_i=1: id_valid_o=1 at N+1 and pops at N+1, so count_o=0 and id_valid_o=0 at N+2.
- 3 entries and branch_flag_i=1 with a simultaneous pc_valid_i: next cycle count_o=0, id_valid_o=0, id_pc_o=0, stall_req_o=0, and the discarded PC never appears. Repeat with flush_i.
- Assert rst low asynchronously mid-cycle with 2 entries: all outputs 0 immediately. Release, then push 0x1c000100: it appears at the head one cycle later.

Source files
------------

// File: rtl/if_inst_queue_pkg.sv
// Shared fetch-side definitions for the instruction fetch queue.
// Bus widths, the zero word and the default queue depth live here.
package if_inst_queue_pkg;

    localparam int          InstAddrBus  = 32;
    localparam int          InstBus      = 32;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        InstValid    = 1'b1;
    localparam logic        InstInvalid  = 1'b0;
    localparam int          IfQueueDepth = 4;

endpackage

// File: rtl/if_inst_queue_fifo_ptr_ctrl.sv
// Read/write pointer and occupancy control for a power-of-two circular FIFO.
// Kill clears everything; pointers wrap naturally modulo DEPTH.
module fifo_ptr_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       kill,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (kill) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // simultaneous push and pop leaves occupancy unchanged
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/if_inst_queue.sv
// First-word-fall-through queue of {pc, inst} pairs between fetch and decode.
// Requests a fetch stall with two slots of skid left for in-flight fetches.
module if_inst_queue
    import if_inst_queue_pkg::*;
#(
    parameter int DEPTH  = IfQueueDepth,
    parameter int ADDR_W = InstAddrBus,
    parameter int INST_W = InstBus
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        pc_i,
    input  logic                     pc_valid_i,
    input  logic [INST_W-1:0]        inst_i,
    input  logic                     flush_i,
    input  logic                     branch_flag_i,
    input  logic                     id_ready_i,
    output logic                     id_valid_o,
    output logic [ADDR_W-1:0]        id_pc_o,
    output logic [INST_W-1:0]        id_inst_o,
    output logic                     stall_req_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             kill;
    logic             push;
    logic             pop;

    assign kill = flush_i || branch_flag_i;
    assign pop  = id_valid_o && id_ready_i && !kill;
    assign push = pc_valid_i && (!full || pop) && !kill;

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .kill   (kill),
        .rd_ptr (rd_ptr),
        .wr_ptr (wr_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // storage has no reset; the head mux masks it while empty
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= pc_i;
            inst_mem[wr_ptr] <= inst_i;
        end
    end

    // a fetch arriving into a full queue with no pop is lost; remember it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_o <= 1'b0;
        end else if (pc_valid_i && full && !pop && !kill) begin
            overflow_o <= 1'b1;
        end
    end

    assign id_valid_o  = empty ? InstInvalid : InstValid;
    assign id_pc_o     = id_valid_o ? pc_mem[rd_ptr]   : ADDR_W'(ZeroWord);
    assign id_inst_o   = id_valid_o ? inst_mem[rd_ptr] : INST_W'(ZeroWord);
    assign stall_req_o = (count >= CNT_W'(DEPTH - 2));
    assign count_o     = count;

endmodule

// File: tb/tb_if_inst_queue.sv
// Directed test of if_inst_queue: stimulus pushes expected head entries into a
// scoreboard queue and a negedge monitor checks every accepted head against it.
module tb_if_inst_queue;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic [31:0] inst_i;
    logic        flush_i;
    logic        branch_flag_i;
    logic        id_ready_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        stall_req_o;
    logic [2:0]  count_o;
    logic        overflow_o;

    entry_t exp_q[$];
    int     model_count;
    int     tests_run;
    int     tests_failed;

    if_inst_queue #(
        .DEPTH  (4),
        .ADDR_W (32),
        .INST_W (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .pc_valid_i    (pc_valid_i),
        .inst_i        (inst_i),
        .flush_i       (flush_i),
        .branch_flag_i (branch_flag_i),
        .id_ready_i    (id_ready_i),
        .id_valid_o    (id_valid_o),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .stall_req_o   (stall_req_o),
        .count_o       (count_o),
        .overflow_o    (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // drive one cycle of inputs, update the expected model, then step past the edge
    task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                                 input logic [31:0] inst, input logic ready,
                                 input logic flush, input logic branch);
        bit kill;
        bit pop;
        bit push;
        pc_valid_i    = valid;
        pc_i          = pc;
        inst_i        = inst;
        id_ready_i    = ready;
        flush_i       = flush;
        branch_flag_i = branch;
        kill = flush || branch;
        pop  = (model_count != 0) && ready && !kill;
        push = valid && (model_count < 4 || pop) && !kill;
        if (kill) begin
            exp_q.delete();
            model_count = 0;
        end else begin
            if (push) begin
                exp_q.push_back('{pc: pc, inst: inst});
            end
            model_count = model_count + (push ? 1 : 0) - (pop ? 1 : 0);
        end
        @(posedge clk);
        #1;
        pc_valid_i    = 1'b0;
        id_ready_i    = 1'b0;
        flush_i       = 1'b0;
        branch_flag_i = 1'b0;
    endtask

    // monitor: every head accepted by decode must match the scoreboard front
    always @(negedge clk) begin
        if (rst && id_valid_o && id_ready_i && !flush_i && !branch_flag_i) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_head: got pc 0x%08h, expected no entry", id_pc_o);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                checkOutput("head_pc", id_pc_o, e.pc);
                checkOutput("head_inst", id_inst_o, e.inst);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        model_count   = 0;
        rst           = 1'b0;
        pc_i          = '0;
        inst_i        = '0;
        pc_valid_i    = 1'b0;
        flush_i       = 1'b0;
        branch_flag_i = 1'b0;
        id_ready_i    = 1'b0;

        @(posedge clk);
        #1;
        checkOutput("rst_count", 32'(count_o), 32'd0);
        checkOutput("rst_valid", 32'(id_valid_o), 32'd0);
        checkOutput("rst_pc", id_pc_o, 32'h0);
        checkOutput("rst_inst", id_inst_o, 32'h0);
        checkOutput("rst_stall", 32'(stall_req_o), 32'd0);
        checkOutput("rst_overflow", 32'(overflow_o), 32'd0);
        #5 rst = 1'b1;
        @(posedge clk);
        #1;

        // three pushes with decode stalled
        applyStimulus(1'b1, 32'h1c000000, 32'h02800401, 1'b0, 1'b0, 1'b0);
        checkOutput("stall_after_1", 32'(stall_req_o), 32'd0);
        checkOutput("valid_after_1", 32'(id_valid_o), 32'd1);
        applyStimulus(1'b1, 32'h1c000004, 32'h02800802, 1'b0, 1'b0, 1'b0);
        checkOutput("stall_after_2", 32'(stall_req_o), 32'd1);
        applyStimulus(1'b1, 32'h1c000008, 32'h02800c03, 1'b0, 1'b0, 1'b0);
        checkOutput("count_3", 32'(count_o), 32'd3);
        checkOutput("head_3", id_pc_o, 32'h1c000000);
        checkOutput("valid_3", 32'(id_valid_o), 32'd1);

        // fill, then overflow
        applyStimulus(1'b1, 32'h1c00000c, 32'h02801004, 1'b0, 1'b0, 1'b0);
        checkOutput("count_full", 32'(count_o), 32'd4);
        checkOutput("no_overflow_yet", 32'(overflow_o), 32'd0);
        applyStimulus(1'b1, 32'h1c000010, 32'h0badbad0, 1'b0, 1'b0, 1'b0);
        checkOutput("overflow_set", 32'(overflow_o), 32'd1);
        checkOutput("count_overflow", 32'(count_o), 32'd4);
        checkOutput("head_overflow", id_pc_o, 32'h1c000000);

        // full with push and pop together
        applyStimulus(1'b1, 32'h1c000014, 32'h02801405, 1'b1, 1'b0, 1'b0);
        checkOutput("count_pushpop", 32'(count_o), 32'd4);
        checkOutput("head_pushpop", id_pc_o, 32'h1c000004);

        // drain across pointer wrap
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("count_drained", 32'(count_o), 32'd0);
        checkOutput("valid_drained", 32'(id_valid_o), 32'd0);
        checkOutput("pc_drained", id_pc_o, 32'h0);

        // push into empty queue with decode ready
        applyStimulus(1'b1, 32'h1c000020, 32'h02802006, 1'b1, 1'b0, 1'b0);
        checkOutput("latency_valid", 32'(id_valid_o), 32'd1);
        checkOutput("latency_count", 32'(count_o), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("popped_valid", 32'(id_valid_o), 32'd0);
        checkOutput("popped_count", 32'(count_o), 32'd0);

        // branch kill with a simultaneous fetch
        applyStimulus(1'b1, 32'h1c000030, 32'h02803007, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h1c000034, 32'h02803408, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h1c000038, 32'h02803809, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h1c00003c, 32'h0badbad1, 1'b1, 1'b0, 1'b1);
        checkOutput("branch_count", 32'(count_o), 32'd0);
        checkOutput("branch_valid", 32'(id_valid_o), 32'd0);
        checkOutput("branch_pc", id_pc_o, 32'h0);
        checkOutput("branch_stall", 32'(stall_req_o), 32'd0);
        checkOutput("branch_overflow", 32'(overflow_o), 32'd1);
        applyStimulus(1'b1, 32'h1c000040, 32'h0280400a, 1'b0, 1'b0, 1'b0);
        checkOutput("after_branch_head", id_pc_o, 32'h1c000040);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // flush kill with a simultaneous fetch
        applyStimulus(1'b1, 32'h1c000050, 32'h0280500b, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h1c000054, 32'h0280540c, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h1c000058, 32'h0280580d, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h1c00005c, 32'h0badbad2, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_count", 32'(count_o), 32'd0);
        checkOutput("flush_valid", 32'(id_valid_o), 32'd0);
        checkOutput("flush_inst", id_inst_o, 32'h0);
        checkOutput("flush_stall", 32'(stall_req_o), 32'd0);
        applyStimulus(1'b1, 32'h1c000044, 32'h0280440e, 1'b0, 1'b0, 1'b0);
        checkOutput("after_flush_head", id_pc_o, 32'h1c000044);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // asynchronous reset with two entries held
        applyStimulus(1'b1, 32'h1c000060, 32'h0280600f, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h1c000064, 32'h02806410, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_reset_count", 32'(count_o), 32'd2);
        #1 rst = 1'b0;
        exp_q.delete();
        model_count = 0;
        #1;
        checkOutput("async_count", 32'(count_o), 32'd0);
        checkOutput("async_valid", 32'(id_valid_o), 32'd0);
        checkOutput("async_pc", id_pc_o, 32'h0);
        checkOutput("async_stall", 32'(stall_req_o), 32'd0);
        checkOutput("async_overflow", 32'(overflow_o), 32'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h1c000100, 32'h02810011, 1'b0, 1'b0, 1'b0);
        checkOutput("post_reset_valid", 32'(id_valid_o), 32'd1);
        checkOutput("post_reset_head", id_pc_o, 32'h1c000100);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("final_count", 32'(count_o), 32'd0);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
